// File: rtl/add3_share_arb.sv
// Round-robin arbiter sharing one external 3-operand 4-bit adder among NREQ requesters.
// Optional macro ADD3_ARB_PRIO0_EN gives requester 0 strict priority over the rotation.
module add3_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_c,
  output logic [3:0]        add_in1,
  output logic [3:0]        add_in2,
  output logic [3:0]        add_in3,
  input  logic [3:0]        add_out1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id
);

  localparam int unsigned N = NREQ;

  typedef enum logic {EMPTY, FULL} rsp_state_t;

  rsp_state_t     state, state_next;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] g;
  logic [IDW-1:0] cand;
  logic           hit;
  logic           can_issue;
  logic [3:0]     a_arr [NREQ];
  logic [3:0]     b_arr [NREQ];
  logic [3:0]     c_arr [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_arr[i] = req_a[4*i +: 4];
      b_arr[i] = req_b[4*i +: 4];
      c_arr[i] = req_c[4*i +: 4];
    end
  end

  assign can_issue = (state == EMPTY) || rsp_ready;

  // Scan starts one past the last winner and wraps; the first valid index wins.
  always_comb begin
    hit  = 1'b0;
    g    = '0;
    cand = '0;
`ifdef ADD3_ARB_PRIO0_EN
    if (can_issue && req_valid[0]) begin
      hit = 1'b1;
      g   = '0;
    end
`endif
    if (can_issue) begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = IDW'((32'(last_grant) + k + 32'd1) % N);
        if (!hit && req_valid[cand]) begin
          hit = 1'b1;
          g   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_in1   = '0;
    add_in2   = '0;
    add_in3   = '0;
    if (hit) begin
      req_ready = NREQ'(1) << g;
      add_in1   = a_arr[g];
      add_in2   = b_arr[g];
      add_in3   = c_arr[g];
    end
  end

  always_comb begin
    state_next = state;
    if (hit)
      state_next = FULL;
    else if (state == FULL && rsp_ready)
      state_next = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= EMPTY;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum    <= '0;
      rsp_id     <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else if (hit) begin
      rsp_sum    <= add_out1;
      rsp_id     <= g;
      last_grant <= g;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule
